// File: rtl/mac_pkg.sv
// mac_pkg: FSM state codes and default requantisation constants for the neuron engine
package mac_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_QUANT = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [31:0] M0_0Q32_DEF = 32'd1932735283;
  localparam int SHIFT_DEF  = 10;
  localparam int OFFSET_DEF = 22;
endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational a*M0*2^-(32+SHIFT) with round-half-up, offset, clamp to N bits and optional ReLU
module requant_sat import mac_pkg::*; #(
  parameter int N = 8,
  parameter int N_ACC = 32,
  parameter logic [31:0] M0_0Q32 = M0_0Q32_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic signed [N_ACC-1:0] acc,
  input  logic                    relu,
  output logic signed [N-1:0]     q
);
  localparam int PW = N_ACC + 34;
  localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (31 + SHIFT);
  localparam logic signed [PW-1:0] MAXV = ({{(PW-1){1'b0}}, 1'b1} << (N - 1)) - 1;
  localparam logic signed [PW-1:0] MINV = -({{(PW-1){1'b0}}, 1'b1} << (N - 1));
  logic signed [PW-1:0] p, s, r;
  // signed x unsigned product, rounded arithmetic shift, zero-point, then saturate and rectify
  always_comb begin
    p = $signed({{(PW-N_ACC){acc[N_ACC-1]}}, acc}) * $signed({{(PW-32){1'b0}}, M0_0Q32});
    s = (p + RND) >>> (32 + SHIFT);
    r = s + PW'(OFFSET);
    q = (relu && r[PW-1]) ? '0 : (r > MAXV) ? MAXV[N-1:0] : (r < MINV) ? MINV[N-1:0] : r[N-1:0];
  end
endmodule

// File: rtl/mac_neuron_engine.sv
// mac_neuron_engine: streaming single-neuron MAC with saturating accumulator and requantised output
module mac_neuron_engine import mac_pkg::*; #(
  parameter int N = 8,
  parameter int N_ACC = 32,
  parameter int FAN_IN = 16,
  parameter logic [31:0] M0_0Q32 = M0_0Q32_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [N_ACC-1:0] bias,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     weight,
  input  logic signed [N-1:0]     in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [N-1:0]     out,
  output logic                    acc_ovf,
  output logic                    busy
);
  localparam int CW = $clog2(FAN_IN + 1);
  localparam logic signed [N_ACC-1:0] ACC_MAX = {1'b0, {(N_ACC-1){1'b1}}};
  localparam logic signed [N_ACC-1:0] ACC_MIN = {1'b1, {(N_ACC-1){1'b0}}};
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic signed [N-1:0] w_r, x_r;
  logic op_v, relu_r, take, sat_hi, sat_lo;
  logic signed [N_ACC-1:0] acc;
  logic signed [2*N-1:0] prod;
  logic signed [N_ACC:0] sum;
  logic signed [N-1:0] q;
  assign in_ready = (state == S_ACC) && (cnt < CW'(FAN_IN));
  assign take = in_valid && in_ready;
  assign busy = state != S_IDLE;
  // one guard bit above the accumulator exposes overflow in either direction
  always_comb begin
    prod = w_r * x_r;
    sum = {acc[N_ACC-1], acc} + {{(N_ACC+1-2*N){prod[2*N-1]}}, prod};
    sat_hi = ~sum[N_ACC] & sum[N_ACC-1];
    sat_lo = sum[N_ACC] & ~sum[N_ACC-1];
  end
  requant_sat #(.N(N), .N_ACC(N_ACC), .M0_0Q32(M0_0Q32), .SHIFT(SHIFT), .OFFSET(OFFSET)) u_rq (
    .acc(acc),
    .relu(relu_r),
    .q(q)
  );
  // operand capture, gated accumulate one edge later, and the neuron sequencing FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      w_r <= '0;
      x_r <= '0;
      op_v <= 1'b0;
      relu_r <= 1'b0;
      acc <= '0;
      out <= '0;
      out_valid <= 1'b0;
      acc_ovf <= 1'b0;
    end else begin
      if (op_v) begin
        acc <= sat_hi ? ACC_MAX : sat_lo ? ACC_MIN : sum[N_ACC-1:0];
        if (sat_hi || sat_lo) acc_ovf <= 1'b1;
      end
      op_v <= take;
      if (take) begin
        w_r <= weight;
        x_r <= in;
        cnt <= cnt + 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          acc <= bias;
          cnt <= '0;
          acc_ovf <= 1'b0;
          relu_r <= relu_en;
          w_r <= '0;
          x_r <= '0;
          state <= S_ACC;
        end
        S_ACC: if (cnt == CW'(FAN_IN)) state <= S_DRAIN;
        S_DRAIN: state <= S_QUANT;
        S_QUANT: begin
          out <= q;
          out_valid <= 1'b1;
          state <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_neuron_engine.sv
// tb_mac_neuron_engine: table-driven and randomised checks of a 32-bit and a 16-bit accumulator build
module tb_mac_neuron_engine;
  localparam int FAN = 16;
  localparam longint M0 = 1932735283;
  logic clk = 0, reset = 0, start = 0, relu_en = 0, in_valid = 0, out_ready = 0;
  logic signed [31:0] bias = 0;
  logic signed [7:0] weight = 0, in = 0;
  logic in_ready, out_valid, acc_ovf, busy;
  logic in_ready16, out_valid16, acc_ovf16, busy16;
  logic signed [7:0] out, out16;
  int vecs = 0, miss = 0;
  int wv[FAN], xv[FAN];

  mac_neuron_engine #(.N(8), .N_ACC(32), .FAN_IN(FAN)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .weight(weight), .in(in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .acc_ovf(acc_ovf), .busy(busy)
  );
  mac_neuron_engine #(.N(8), .N_ACC(16), .FAN_IN(FAN)) u_d16 (
    .clk(clk), .reset(reset), .start(start), .bias(bias[15:0]), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready16), .weight(weight), .in(in),
    .out_valid(out_valid16), .out_ready(out_ready), .out(out16), .acc_ovf(acc_ovf16), .busy(busy16)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // reference: per-beat saturating sum, then real-valued scaling with round-half-up
  function automatic int model(input longint b, input logic r, input int nacc, output logic ov);
    longint hi, lo, a, s;
    hi = (longint'(1) <<< (nacc - 1)) - 1;
    lo = -hi - 1;
    a = b;
    ov = 0;
    for (int i = 0; i < FAN; i++) begin
      a += longint'(wv[i] * xv[i]);
      if (a > hi) begin a = hi; ov = 1; end
      else if (a < lo) begin a = lo; ov = 1; end
    end
    s = ((a * M0) + (longint'(1) <<< 41)) >>> 42;
    s += 22;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (r && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic run_neuron(input string nm, input longint b, input logic r, input int mode, input int hold,
                            input int eo, input int eo16, input logic ev, input logic ev16);
    int idx, guard, lat;
    logic ok;
    logic signed [7:0] o1, o2;
    start = 1; bias = b[31:0]; relu_en = r;
    @(posedge clk); @(negedge clk);
    start = 0;
    chk({nm, ":busy"}, busy, 1);
    chk({nm, ":ovf_clr"}, acc_ovf16, 0);
    idx = 0; guard = 0;
    while (idx < FAN && guard < 500) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(guard % 2) : logic'($urandom_range(99) >= 30);
      weight = 8'(wv[idx]); in = 8'(xv[idx]);
      ok = in_valid && in_ready;
      @(posedge clk); @(negedge clk);
      if (ok) idx++;
      guard++;
    end
    in_valid = 0;
    chk({nm, ":beats"}, idx, FAN);
    chk({nm, ":in_ready_drop"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk({nm, ":latency"}, lat, 3);
    o1 = out; o2 = out16;
    for (int h = 0; h < hold; h++) begin
      start = 1; in_valid = 1; out_ready = 0;
      @(posedge clk); @(negedge clk);
      chk({nm, ":hold_out"}, out, o1);
      chk({nm, ":hold_valid"}, out_valid, 1);
      chk({nm, ":hold_ready"}, in_ready, 0);
    end
    start = 0; in_valid = 0; out_ready = 1;
    chk({nm, ":out"}, out, eo);
    chk({nm, ":out16"}, out16, eo16);
    chk({nm, ":ovf"}, acc_ovf, ev);
    chk({nm, ":ovf16"}, acc_ovf16, ev16);
    chk({nm, ":valid16"}, out_valid16, 1);
    @(posedge clk); @(negedge clk);
    out_ready = 0;
    chk({nm, ":drop_valid"}, out_valid, 0);
    chk({nm, ":idle"}, busy, 0);
  endtask

  typedef struct {
    string nm;
    longint b;
    logic r;
    int w, x, mode, hold, eo, eo16;
    logic ev, ev16;
  } vec_t;

  initial begin
    vec_t tbl[11];
    logic ev, ev16;
    int eo, eo16, hold;
    longint b;
    logic r;
    tbl = '{
      '{"pos80",      0,           0,   80,   80, 0, 5,   67, 36, 0, 1},
      '{"pos80_gap",  0,           0,   80,   80, 1, 0,   67, 36, 0, 1},
      '{"sat127",     0,           0,  127,  127, 0, 1,  127, 36, 0, 1},
      '{"neg80",      0,           0,  -80,   80, 2, 0,  -23,  8, 0, 1},
      '{"neg80_relu", 0,           1,  -80,   80, 0, 2,    0,  8, 0, 1},
      '{"bias1000",   1000,        0,    0,    0, 0, 0,   22, 22, 0, 0},
      '{"zero_relu",  0,           1,    0,    0, 0, 0,   22, 22, 0, 0},
      '{"neg_bias",   -100000,     0,    0,    0, 0, 0,  -22, 36, 0, 0},
      '{"m128sq",     0,           0, -128, -128, 2, 0,  127, 36, 0, 1},
      '{"mix",        0,           0, -128,  127, 0, 0,  -92,  8, 0, 1},
      '{"acc_sat",    2147483547,  0,  127,  127, 0, 0,  127, 36, 1, 1}
    };
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_out", out, 0);
    chk("rst_ovf", acc_ovf, 0);
    reset = 1;
    @(negedge clk);
    foreach (tbl[i]) begin
      for (int k = 0; k < FAN; k++) begin wv[k] = tbl[i].w; xv[k] = tbl[i].x; end
      run_neuron(tbl[i].nm, tbl[i].b, tbl[i].r, tbl[i].mode, tbl[i].hold,
                 tbl[i].eo, tbl[i].eo16, tbl[i].ev, tbl[i].ev16);
    end
    for (int k = 0; k < FAN; k++) begin wv[k] = 50; xv[k] = 60; end
    start = 1; bias = 0; relu_en = 0;
    @(posedge clk); @(negedge clk);
    start = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1; weight = 8'(wv[k]); in = 8'(xv[k]);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 0; reset = 0;
    @(posedge clk); @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_acc", u_dut.acc, 0);
    chk("midrst_out", out, 0);
    reset = 1;
    @(negedge clk);
    for (int k = 0; k < FAN; k++) begin wv[k] = 0; xv[k] = 0; end
    run_neuron("after_rst", 1000, 0, 0, 0, 22, 22, 0, 0);
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < FAN; k++) begin
        wv[k] = int'($urandom_range(255)) - 128;
        xv[k] = int'($urandom_range(255)) - 128;
      end
      b = (n % 4 == 3) ? longint'($signed($urandom())) : longint'(int'($urandom_range(2000000)) - 1000000);
      r = logic'($urandom_range(1));
      hold = int'($urandom_range(3));
      eo = model(b, r, 32, ev);
      eo16 = model(longint'($signed(b[15:0])), r, 16, ev16);
      run_neuron($sformatf("rand%0d", n), b, r, 2, hold, eo, eo16, ev, ev16);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
